// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: issue/stall control for the five-stage stalling_cpu pipeline.
// There is no forwarding, so every RAW hazard against an instruction in EX, MEM or
// WB stalls ID. A multi-cycle ALU op holds EX for MULT_LAT cycles. During the final
// cycle (cnt==1) the op moves on and a new instruction may issue alongside it.
module pipe_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int MULT_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wen,
    input  logic             id_multi,
    input  logic             flush,
    output logic             issue,
    output logic             stall,
    output logic             bubble,
    output logic             ex_hold
);
    localparam int CNT_W = $clog2(MULT_LAT + 1);

    typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} state_t;

    // One scoreboard slot: destination of the instruction in that stage.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_t;

    sb_t              sb [3];   // [0]=EX, [1]=MEM, [2]=WB
    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic hazard;
    logic hold_i;
    logic issue_i;

    // RAW check of both used sources against every live destination; r0 never conflicts.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb[i].v && id_rs1_used && (id_rs1 != '0) && (sb[i].rd == id_rs1))
                hazard = 1'b1;
            if (sb[i].v && id_rs2_used && (id_rs2 != '0) && (sb[i].rd == id_rs2))
                hazard = 1'b1;
        end
    end

    // EX is frozen for every MULTI cycle except the last one.
    assign hold_i  = (state == MULTI) && (cnt != CNT_W'(1));
    assign issue_i = id_valid && !hazard && !hold_i && !flush;

    // Outputs are forced low while reset is asserted, without waiting for a clock edge.
    assign issue   = issue_i && !rst;
    assign stall   = id_valid && !issue_i && !flush && !rst;
    assign bubble  = !hold_i && !issue_i && !rst;
    assign ex_hold = hold_i && !rst;

    // Advance the scoreboard and the multi-cycle sequencer; flush clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) sb[i] <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) sb[i] <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else if (hold_i) begin
            // EX is held, so MEM receives a NOP while WB drains.
            sb[2] <= sb[1];
            sb[1] <= '0;
            cnt   <= cnt - CNT_W'(1);
        end else begin
            sb[2]    <= sb[1];
            sb[1]    <= sb[0];
            sb[0].v  <= issue_i && id_wen && (id_rd != '0);
            sb[0].rd <= id_rd;
            if (issue_i && id_multi) begin
                state <= MULTI;
                cnt   <= CNT_W'(MULT_LAT);
            end else begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected outputs.
// The output vector is {issue, stall, bubble, ex_hold}.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_wen, id_multi, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       issue, stall, bubble, ex_hold;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.REG_W(5), .MULT_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_multi(id_multi), .flush(flush),
        .issue(issue), .stall(stall), .bubble(bubble), .ex_hold(ex_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [3:0] exp);
        #1 chk(tag, {28'd0, issue, stall, bubble, ex_hold}, {28'd0, exp});
    endtask

    // Move to just after the next rising edge, which is where new inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic multi);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wen = wen; id_multi = multi;
    endtask

    task automatic drain(input string tag);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            outs(tag, 4'b0010);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        set_id(1, 0, 0, 0, 0, 5'd1, 1, 0);
        #2 outs("reset_mask", 4'b0000);
        tick();
        rst = 1'b0;

        // RAW after a single-cycle producer: three stalls, then issue.
        set_id(1, 0, 0, 0, 0, 5'd3, 1, 0);
        outs("raw_prod", 4'b1000);
        tick();
        set_id(1, 5'd3, 1, 0, 0, 5'd4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            outs($sformatf("raw_stall%0d", i), 4'b0110);
            tick();
        end
        outs("raw_issue", 4'b1000);
        tick();
        drain("raw_drain");

        // A producer with rd=0 or wen=0 creates no hazard.
        set_id(1, 0, 0, 0, 0, 5'd0, 1, 0);
        outs("rd0_prod", 4'b1000);
        tick();
        set_id(1, 5'd0, 1, 0, 0, 5'd6, 0, 0);
        outs("rd0_cons", 4'b1000);
        tick();
        set_id(1, 0, 0, 0, 0, 5'd5, 0, 0);
        outs("wen0_prod", 4'b1000);
        tick();
        set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0);
        outs("wen0_cons", 4'b1000);
        tick();
        drain("nohaz_drain");

        // Multi-cycle op followed by an independent instruction.
        set_id(1, 0, 0, 0, 0, 5'd9, 1, 1);
        outs("m_issue", 4'b1000);
        tick();
        set_id(1, 5'd1, 1, 0, 0, 5'd2, 1, 0);
        for (int i = 0; i < 3; i++) begin
            outs($sformatf("m_hold%0d", i), 4'b0101);
            tick();
        end
        chk("m_cnt_last", 32'(dut.cnt), 32'd1);
        outs("m_follow_issue", 4'b1000);
        tick();
        drain("m_drain");

        // Multi-cycle rd=7 followed by a consumer of r7 on rs2; MEM slot empties during hold.
        set_id(1, 0, 0, 0, 0, 5'd10, 1, 0);
        outs("d_pre", 4'b1000);
        tick();
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        outs("d_multi", 4'b1000);
        tick();
        set_id(1, 0, 0, 5'd7, 1, 5'd8, 1, 0);
        chk("d_sb1_pre", 32'(dut.sb[1].v), 32'd1);
        for (int i = 0; i < 3; i++) begin
            outs($sformatf("d_hold%0d", i), 4'b0101);
            if (i > 0) chk($sformatf("d_sb1_inv%0d", i), 32'(dut.sb[1].v), 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            outs($sformatf("d_stall%0d", i), 4'b0110);
            tick();
        end
        outs("d_issue", 4'b1000);
        tick();
        drain("d_drain");

        // Flush in the second MULTI cycle while a dependent instruction waits.
        set_id(1, 0, 0, 0, 0, 5'd7, 1, 1);
        outs("f_multi", 4'b1000);
        tick();
        set_id(1, 5'd7, 1, 0, 0, 5'd8, 1, 0);
        outs("f_wait", 4'b0101);
        tick();
        flush = 1'b1;
        outs("f_flush", 4'b0001);
        tick();
        flush = 1'b0;
        #1;
        chk("f_state", 32'(dut.state), 32'd0);
        chk("f_cnt", 32'(dut.cnt), 32'd0);
        chk("f_sb_empty", {29'd0, dut.sb[0].v, dut.sb[1].v, dut.sb[2].v}, 32'd0);
        outs("f_reissue", 4'b1000);
        tick();
        drain("f_drain");

        // Asynchronous reset mid-MULTI with two live scoreboard entries.
        set_id(1, 0, 0, 0, 0, 5'd11, 1, 0);
        outs("r_prod", 4'b1000);
        tick();
        set_id(1, 0, 0, 0, 0, 5'd12, 1, 1);
        outs("r_multi", 4'b1000);
        tick();
        set_id(1, 5'd12, 1, 0, 0, 5'd13, 1, 0);
        outs("r_wait", 4'b0101);
        #2 rst = 1'b1;
        outs("r_async", 4'b0000);
        tick();
        rst = 1'b0;
        #1;
        chk("r_state", 32'(dut.state), 32'd0);
        chk("r_sb_empty", {29'd0, dut.sb[0].v, dut.sb[1].v, dut.sb[2].v}, 32'd0);
        outs("r_issue", 4'b1000);
        tick();
        drain("r_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
